// File: rtl/instr_fetch_decode.sv
// PDP-8 fetch/decode: one request per instruction, RD_LATENCY-cycle read, decoded opcodes held
// from the cycle after DECODE until the exec unit drops stall, then refetch at PC_value.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 12
`endif
`ifndef START_ADDRESS
`define START_ADDRESS 12'o0200
`endif
`ifndef IAC
`define IAC     12'o7001
`define RAL     12'o7004
`define RTL     12'o7006
`define RAR     12'o7010
`define RTR     12'o7012
`define CML     12'o7020
`define CMA     12'o7040
`define CIA     12'o7041
`define CLL     12'o7100
`define CLA1    12'o7200
`define CLA_CLL 12'o7300
`define HLT     12'o7402
`define OSR     12'o7404
`define SKP     12'o7410
`define SNL     12'o7420
`define SZL     12'o7430
`define SZA     12'o7440
`define SNA     12'o7450
`define SMA     12'o7500
`define SPA     12'o7510
`define CLA2    12'o7600
`endif

// pdp_mem_opcode = {AND,TAD,ISZ,DCA,JMS,JMP,mem_inst_addr[8:0]}
// pdp_op7_opcode = {NOP,IAC,RAL,RTL,RAR,RTR,CML,CMA,CIA,CLL,CLA1,CLA_CLL,HLT,OSR,SKP,SNL,SZL,SZA,SNA,SMA,SPA,CLA2}
module instr_fetch_decode #(
  parameter int RD_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   ifu_rd_req,
  output logic [`ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [`DATA_WIDTH-1:0] ifu_rd_data,
  output logic [`ADDR_WIDTH-1:0] base_addr,
  output logic [14:0]            pdp_mem_opcode,
  output logic [21:0]            pdp_op7_opcode,
  input  logic                   stall,
  input  logic [`ADDR_WIDTH-1:0] PC_value
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] DECODE = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;
  localparam logic [2:0] EXEC   = 3'd5;

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  logic [2:0]             state;
  logic [2:0]             lat_cnt;
  logic [`ADDR_WIDTH-1:0] fetch_addr;
  logic [`DATA_WIDTH-1:0] instr_word;
  logic [14:0]            dec_mem;
  logic [21:0]            dec_op7;

  assign base_addr = `START_ADDRESS;

  always_comb begin
    dec_mem = '0;
    dec_op7 = '0;
    case (instr_word[11:9])
      3'd0: dec_mem = {6'b100000, instr_word[8:0]};
      3'd1: dec_mem = {6'b010000, instr_word[8:0]};
      3'd2: dec_mem = {6'b001000, instr_word[8:0]};
      3'd3: dec_mem = {6'b000100, instr_word[8:0]};
      3'd4: dec_mem = {6'b000010, instr_word[8:0]};
      3'd5: dec_mem = {6'b000001, instr_word[8:0]};
      3'd6: dec_op7[21] = 1'b1;
      default: begin
        // Only exact microinstruction encodings are recognised; combinations fall to NOP.
        case (instr_word)
          `IAC:     dec_op7[20] = 1'b1;
          `RAL:     dec_op7[19] = 1'b1;
          `RTL:     dec_op7[18] = 1'b1;
          `RAR:     dec_op7[17] = 1'b1;
          `RTR:     dec_op7[16] = 1'b1;
          `CML:     dec_op7[15] = 1'b1;
          `CMA:     dec_op7[14] = 1'b1;
          `CIA:     dec_op7[13] = 1'b1;
          `CLL:     dec_op7[12] = 1'b1;
          `CLA1:    dec_op7[11] = 1'b1;
          `CLA_CLL: dec_op7[10] = 1'b1;
          `HLT:     dec_op7[9]  = 1'b1;
          `OSR:     dec_op7[8]  = 1'b1;
          `SKP:     dec_op7[7]  = 1'b1;
          `SNL:     dec_op7[6]  = 1'b1;
          `SZL:     dec_op7[5]  = 1'b1;
          `SZA:     dec_op7[4]  = 1'b1;
          `SNA:     dec_op7[3]  = 1'b1;
          `SMA:     dec_op7[2]  = 1'b1;
          `SPA:     dec_op7[1]  = 1'b1;
          `CLA2:    dec_op7[0]  = 1'b1;
          default:  dec_op7[21] = 1'b1;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      fetch_addr     <= `START_ADDRESS;
      instr_word     <= '0;
      ifu_rd_req     <= 1'b0;
      ifu_rd_addr    <= '0;
      pdp_mem_opcode <= '0;
      pdp_op7_opcode <= '0;
    end else begin
      case (state)
        IDLE: begin
          ifu_rd_req  <= 1'b1;
          ifu_rd_addr <= fetch_addr;
          state       <= FETCH;
        end
        FETCH: begin
          ifu_rd_req <= 1'b0;
          lat_cnt    <= 3'd1;
          state      <= WAIT;
        end
        WAIT: begin
          if (lat_cnt == LAT) begin
            instr_word <= ifu_rd_data;
            state      <= DECODE;
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        DECODE: begin
          pdp_mem_opcode <= dec_mem;
          pdp_op7_opcode <= dec_op7;
          state          <= HOLD;
        end
        HOLD: begin
          if (stall) state <= EXEC;
        end
        EXEC: begin
          // Request is raised on the same edge as the clear so structs are zero whenever req=1.
          if (!stall) begin
            fetch_addr     <= PC_value;
            ifu_rd_addr    <= PC_value;
            ifu_rd_req     <= 1'b1;
            pdp_mem_opcode <= '0;
            pdp_op7_opcode <= '0;
            state          <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Bench for instr_fetch_decode: a latency-1 and a latency-3 instance, exercised one at a time
// against a table-driven decode model and a cycle-count model of the fetch handshake.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst_n1, rst_n3, stall;
  logic [11:0] rd_data, pc_value;
  logic        req1, req3;
  logic [11:0] addr1, addr3, base1, base3;
  logic [14:0] mem1, mem3;
  logic [21:0] op7_1, op7_3;

  always #5 clk = ~clk;

  instr_fetch_decode #(.RD_LATENCY(1)) dut1 (
    .clk(clk), .reset_n(rst_n1), .ifu_rd_req(req1), .ifu_rd_addr(addr1),
    .ifu_rd_data(rd_data), .base_addr(base1), .pdp_mem_opcode(mem1),
    .pdp_op7_opcode(op7_1), .stall(stall), .PC_value(pc_value));

  instr_fetch_decode #(.RD_LATENCY(3)) dut3 (
    .clk(clk), .reset_n(rst_n3), .ifu_rd_req(req3), .ifu_rd_addr(addr3),
    .ifu_rd_data(rd_data), .base_addr(base3), .pdp_mem_opcode(mem3),
    .pdp_op7_opcode(op7_3), .stall(stall), .PC_value(pc_value));

  int          sel = 1;
  logic        req_s;
  logic [11:0] addr_s, base_s;
  logic [14:0] mem_s;
  logic [21:0] op7_s;

  always_comb begin
    req_s  = (sel == 3) ? req3  : req1;
    addr_s = (sel == 3) ? addr3 : addr1;
    base_s = (sel == 3) ? base3 : base1;
    mem_s  = (sel == 3) ? mem3  : mem1;
    op7_s  = (sel == 3) ? op7_3 : op7_1;
  end

  int tests  = 0;
  int failed = 0;
  logic [11:0] cur_addr;

  // Operate-group encodings in the order of pdp_op7_opcode bits 20 down to 0.
  logic [11:0] op7_tab [21] = '{12'o7001, 12'o7004, 12'o7006, 12'o7010, 12'o7012, 12'o7020,
                                12'o7040, 12'o7041, 12'o7100, 12'o7200, 12'o7300, 12'o7402,
                                12'o7404, 12'o7410, 12'o7420, 12'o7430, 12'o7440, 12'o7450,
                                12'o7500, 12'o7510, 12'o7600};

  function automatic logic [36:0] ref_decode(input logic [11:0] w);
    int          op;
    logic [14:0] m;
    logic [21:0] o;
    op = int'(w) / 512;
    m  = '0;
    o  = '0;
    if (op < 6) begin
      m = 15'((1 << (14 - op)) | (int'(w) % 512));
    end else begin
      o[21] = 1'b1;
      if (op == 7)
        for (int i = 0; i < 21; i++)
          if (w == op7_tab[i]) o = 22'(1) << (20 - i);
    end
    return {m, o};
  endfunction

  function automatic logic [11:0] rand_word();
    if ($urandom_range(0, 1) == 1) return op7_tab[$urandom_range(0, 20)];
    return 12'($urandom);
  endfunction

  // Entered at the negedge of a FETCH cycle; returns at the negedge of the next FETCH cycle.
  task automatic run_instr(input logic [11:0] word, input bit pre, input int hold_d,
                           input int len, input logic [11:0] next_pc, input string tag);
    int          lat;
    logic [36:0] e;
    lat = (sel == 3) ? 3 : 1;
    e   = ref_decode(word);
    tests++;
    if (req_s !== 1'b1 || addr_s !== cur_addr || mem_s !== 15'd0 || op7_s !== 22'd0 || base_s !== 12'o0200) begin
      failed++;
      $display("FAIL %s fetch: req=%b addr=%o mem=%h op7=%h base=%o, want req=1 addr=%o structs 0 base 0200",
               tag, req_s, addr_s, mem_s, op7_s, base_s, cur_addr);
    end
    stall    = 1'($urandom_range(0, 1));
    rd_data  = 12'($urandom);
    pc_value = 12'($urandom);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      tests++;
      if (req_s !== 1'b0 || addr_s !== cur_addr || mem_s !== 15'd0 || op7_s !== 22'd0) begin
        failed++;
        $display("FAIL %s wait%0d: req=%b addr=%o mem=%h op7=%h, want req=0 addr=%o structs 0",
                 tag, k, req_s, addr_s, mem_s, op7_s, cur_addr);
      end
      stall   = 1'($urandom_range(0, 1));
      rd_data = (k == lat) ? word : 12'($urandom);
    end
    @(negedge clk);
    rd_data = 12'($urandom);
    stall   = pre;
    for (int i = 0; i <= (pre ? 0 : hold_d); i++) begin
      @(negedge clk);
      tests++;
      if (req_s !== 1'b0 || mem_s !== e[36:22] || op7_s !== e[21:0]) begin
        failed++;
        $display("FAIL %s hold%0d word=%o: req=%b mem=%h op7=%h, want req=0 mem=%h op7=%h",
                 tag, i, word, req_s, mem_s, op7_s, e[36:22], e[21:0]);
      end
      rd_data = 12'($urandom);
    end
    stall = 1'b1;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      tests++;
      if (req_s !== 1'b0 || mem_s !== e[36:22] || op7_s !== e[21:0]) begin
        failed++;
        $display("FAIL %s exec%0d word=%o: req=%b mem=%h op7=%h, want req=0 mem=%h op7=%h",
                 tag, j, word, req_s, mem_s, op7_s, e[36:22], e[21:0]);
      end
      if (j == len) begin
        stall    = 1'b0;
        pc_value = next_pc;
      end else begin
        pc_value = 12'($urandom);
      end
    end
    @(negedge clk);
    cur_addr = next_pc;
  endtask

  task automatic test_reset();
    rst_n1 = 1'b0; rst_n3 = 1'b0; stall = 1'b0; rd_data = '0; pc_value = '0;
    repeat (3) @(negedge clk);
    tests++;
    if (req1 !== 1'b0 || addr1 !== 12'd0 || mem1 !== 15'd0 || op7_1 !== 22'd0 || base1 !== 12'o0200) begin
      failed++;
      $display("FAIL reset_dut1: req=%b addr=%o mem=%h op7=%h base=%o, want 0/0/0/0/0200",
               req1, addr1, mem1, op7_1, base1);
    end
    tests++;
    if (req3 !== 1'b0 || addr3 !== 12'd0 || mem3 !== 15'd0 || op7_3 !== 22'd0 || base3 !== 12'o0200) begin
      failed++;
      $display("FAIL reset_dut3: req=%b addr=%o mem=%h op7=%h base=%o, want 0/0/0/0/0200",
               req3, addr3, mem3, op7_3, base3);
    end
    sel      = 1;
    rst_n1   = 1'b1;
    cur_addr = 12'o0200;
    @(negedge clk);
  endtask

  task automatic test_mem_ops();
    run_instr(12'o1234, 1'b0, 2, 3, 12'o0210, "tad_1234");
    for (int op = 0; op < 6; op++)
      run_instr(12'(op * 512 + int'($urandom_range(0, 511))), 1'b0,
                int'($urandom_range(0, 3)), int'($urandom_range(1, 4)), 12'($urandom), "mem_op");
  endtask

  task automatic test_op7();
    run_instr(12'o7041, 1'b0, 0, 4, 12'o0300, "cia");
    run_instr(12'o7003, 1'b0, 1, 2, 12'($urandom), "nop_7003");
    run_instr(12'o6001, 1'b0, 1, 2, 12'($urandom), "iot_6001");
    for (int i = 0; i < 21; i++)
      run_instr(op7_tab[i], 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(1, 3)), 12'($urandom), "op7_tab");
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++)
      run_instr(rand_word(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(1, 5)), 12'($urandom), "random");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++)
      run_instr(rand_word(), 1'b1, 0, 1, 12'($urandom), "b2b");
  endtask

  task automatic test_reset_in_wait(input string tag);
    logic [11:0] w;
    w = 12'o1234;
    @(negedge clk);
    rd_data = w;
    if (sel == 3) rst_n3 = 1'b0; else rst_n1 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (req_s !== 1'b0 || addr_s !== 12'd0 || mem_s !== 15'd0 || op7_s !== 22'd0) begin
        failed++;
        $display("FAIL %s in_reset%0d: req=%b addr=%o mem=%h op7=%h, want all 0",
                 tag, i, req_s, addr_s, mem_s, op7_s);
      end
    end
    if (sel == 3) rst_n3 = 1'b1; else rst_n1 = 1'b1;
    cur_addr = 12'o0200;
    @(negedge clk);
    run_instr(12'o5077, 1'b0, 1, 2, 12'($urandom), {tag, "_restart"});
  endtask

  task automatic test_latency3();
    rst_n1   = 1'b0;
    sel      = 3;
    rst_n3   = 1'b1;
    cur_addr = 12'o0200;
    @(negedge clk);
    run_instr(12'o1234, 1'b0, 1, 2, 12'o0300, "lat3_tad");
    run_instr(12'o7041, 1'b1, 0, 1, 12'($urandom), "lat3_cia");
    for (int i = 0; i < 12; i++)
      run_instr(rand_word(), 1'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                int'($urandom_range(1, 3)), 12'($urandom), "lat3_random");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mem_ops();
    test_op7();
    test_random();
    test_back_to_back();
    test_reset_in_wait("rst_wait_lat1");
    test_latency3();
    test_reset_in_wait("rst_wait_lat3");
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
